// File: rtl/pipeline_pkg.sv
// Shared types for the RV32 pipeline hazard controller: forwarding selects
// and hazard FSM states.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        TIMEOUT  = 2'b10
    } hz_state_t;

endpackage

// File: rtl/forwarding_unit.sv
// EX-stage operand forwarding: picks the youngest in-flight producer of each
// ALU source register, never forwarding for x0.
module forwarding_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  mem_regWrite,
    input  logic                  wb_regWrite,
    output fwd_sel_t              fwd_a,
    output fwd_sel_t              fwd_b
);

    logic mem_valid;
    logic wb_valid;

    assign mem_valid = mem_regWrite && (mem_rd != '0);
    assign wb_valid  = wb_regWrite  && (wb_rd  != '0);

    // EX/MEM holds the more recent result, so it wins over MEM/WB
    always_comb begin
        fwd_a = FWD_REG;
        if (mem_valid && (mem_rd == ex_rs1)) begin
            fwd_a = FWD_EXMEM;
        end else if (wb_valid && (wb_rd == ex_rs1)) begin
            fwd_a = FWD_MEMWB;
        end
    end

    always_comb begin
        fwd_b = FWD_REG;
        if (mem_valid && (mem_rd == ex_rs2)) begin
            fwd_b = FWD_EXMEM;
        end else if (wb_valid && (wb_rd == ex_rs2)) begin
            fwd_b = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: stage
// enables/flushes, memory wait-state FSM with timeout, forwarding, perf counters.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned REG_ADDR_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_memRead,
    input  logic                  ex_branch_taken,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  mem_regWrite,
    input  logic                  wb_regWrite,
    input  logic                  mem_req,
    input  logic                  dmem_ready,
    output logic                  pc_en,
    output logic                  if_id_en,
    output logic                  id_ex_en,
    output logic                  ex_mem_en,
    output logic                  mem_wb_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic [1:0]            fwdA,
    output logic [1:0]            fwdB,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

    hz_state_t         state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              freeze;
    logic              load_use;
    logic              branch_flush;
    fwd_sel_t          fwd_a_sel;
    fwd_sel_t          fwd_b_sel;

    forwarding_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd (
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .mem_rd       (mem_rd),
        .wb_rd        (wb_rd),
        .mem_regWrite (mem_regWrite),
        .wb_regWrite  (wb_regWrite),
        .fwd_a        (fwd_a_sel),
        .fwd_b        (fwd_b_sel)
    );

    assign fwdA = reset ? FWD_REG : fwd_a_sel;
    assign fwdB = reset ? FWD_REG : fwd_b_sel;

    assign freeze = ((state == RUN) && mem_req && !dmem_ready)
                 || ((state == MEM_WAIT) && !dmem_ready)
                 || (state == TIMEOUT);

    assign load_use = ex_memRead && (ex_rd != '0)
                   && ((id_uses_rs1 && (id_rs1 == ex_rd))
                    || (id_uses_rs2 && (id_rs2 == ex_rd)));

    // Priority: freeze > branch > load-use. A branch flush squashes the
    // younger load-use consumer anyway, so no stall is needed alongside it.
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        branch_flush = 1'b0;
        if (!reset && !freeze) begin
            if (ex_branch_taken) begin
                pc_en        = 1'b1;
                if_id_en     = 1'b1;
                id_ex_en     = 1'b1;
                ex_mem_en    = 1'b1;
                mem_wb_en    = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                branch_flush = 1'b1;
            end else if (load_use) begin
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !dmem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        if ((MEM_TIMEOUT != 0) && (wait_cnt == TIMEOUT_CNT)) begin
                            state       <= TIMEOUT;
                            mem_timeout <= 1'b1;
                        end
                        // saturate so a disabled timeout never wraps the count
                        if (wait_cnt != '1) begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                end
                TIMEOUT: begin
                    mem_timeout <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase

            if (!pc_en && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (branch_flush && (flush_events != '1)) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl with hand-written
// sequences for memory wait, timeout, saturation and reset corners.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned REG_ADDR_W  = 5;

    logic                  clk;
    logic                  reset;
    logic [REG_ADDR_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic                  id_uses_rs1, id_uses_rs2, ex_memRead, ex_branch_taken;
    logic                  mem_regWrite, wb_regWrite, mem_req, dmem_ready;
    logic                  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic                  if_id_flush, id_ex_flush, mem_timeout;
    logic [1:0]            fwdA, fwdB;
    logic [CNT_W-1:0]      stall_cycles, flush_events;

    int errors = 0;
    int checks = 0;

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W),
        .REG_ADDR_W  (REG_ADDR_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rs1          (ex_rs1),
        .ex_rs2          (ex_rs2),
        .ex_rd           (ex_rd),
        .ex_memRead      (ex_memRead),
        .ex_branch_taken (ex_branch_taken),
        .mem_rd          (mem_rd),
        .wb_rd           (wb_rd),
        .mem_regWrite    (mem_regWrite),
        .wb_regWrite     (wb_regWrite),
        .mem_req         (mem_req),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .fwdA            (fwdA),
        .fwdB            (fwdB),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // en = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id_flush, id_ex_flush}
    typedef struct {
        int id_rs1, id_rs2, u1, u2;
        int ex_rs1, ex_rs2, ex_rd, mrd, br;
        int mem_rd, wb_rd, mem_rw, wb_rw;
        int exp_en, exp_fl, exp_fa, exp_fb;
    } vec_t;

    vec_t vecs[12];

    function automatic int en_bits();
        return int'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en});
    endfunction

    function automatic int fl_bits();
        return int'({if_id_flush, id_ex_flush});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_memRead = 1'b0;
        ex_branch_taken = 1'b0; mem_rd = '0; wb_rd = '0;
        mem_regWrite = 1'b0; wb_regWrite = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Called at a negedge; returns at a later negedge with reset released.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        ex_memRead = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        ex_branch_taken = 1'b1; mem_req = 1'b1; dmem_ready = 1'b0;
        ex_rs1 = 5'd7; ex_rs2 = 5'd7; mem_rd = 5'd7; mem_regWrite = 1'b1;
        #1;
        chk({tag, "_rst_en"}, en_bits(), 0);
        chk({tag, "_rst_fl"}, fl_bits(), 0);
        chk({tag, "_rst_fwd"}, int'({fwdA, fwdB}), 0);
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        do_reset("init");
        #1;
        chk("init_stall", int'(stall_cycles), 0);
        chk("init_flush", int'(flush_events), 0);
        chk("init_tmo", int'(mem_timeout), 0);
        chk("init_en", en_bits(), 5'b11111);

        //           id1 id2 u1 u2 ers1 ers2 erd mrd br mrd_ wrd mrw wrw  en      fl     fa fb
        vecs[0]  = '{0,  0,  0, 0, 0,   0,   0,  0,  0, 0,  0,  0,  0,  5'b11111, 2'b00, 0, 0};
        vecs[1]  = '{5,  0,  1, 0, 0,   0,   5,  1,  0, 0,  0,  0,  0,  5'b00111, 2'b01, 0, 0};
        vecs[2]  = '{0,  0,  1, 0, 0,   0,   0,  1,  0, 0,  0,  0,  0,  5'b11111, 2'b00, 0, 0};
        vecs[3]  = '{1,  9,  0, 1, 0,   0,   9,  1,  0, 0,  0,  0,  0,  5'b00111, 2'b01, 0, 0};
        vecs[4]  = '{6,  0,  0, 0, 0,   0,   6,  1,  0, 0,  0,  0,  0,  5'b11111, 2'b00, 0, 0};
        vecs[5]  = '{6,  0,  1, 0, 0,   0,   6,  0,  0, 0,  0,  0,  0,  5'b11111, 2'b00, 0, 0};
        vecs[6]  = '{5,  0,  1, 0, 0,   0,   5,  1,  1, 0,  0,  0,  0,  5'b11111, 2'b11, 0, 0};
        vecs[7]  = '{0,  0,  0, 0, 7,   0,   0,  0,  0, 7,  7,  1,  1,  5'b11111, 2'b00, 1, 0};
        vecs[8]  = '{0,  0,  0, 0, 7,   0,   0,  0,  0, 7,  7,  0,  1,  5'b11111, 2'b00, 2, 0};
        vecs[9]  = '{0,  0,  0, 0, 0,   0,   0,  0,  0, 0,  0,  1,  1,  5'b11111, 2'b00, 0, 0};
        vecs[10] = '{0,  0,  0, 0, 3,   3,   0,  0,  0, 3,  3,  1,  1,  5'b11111, 2'b00, 1, 1};
        vecs[11] = '{0,  0,  0, 0, 8,   4,   0,  0,  0, 4,  4,  0,  1,  5'b11111, 2'b00, 0, 2};

        begin
            int exp_stall = 0;
            int exp_flush = 0;
            for (int i = 0; i < 12; i++) begin
                id_rs1 = 5'(vecs[i].id_rs1); id_rs2 = 5'(vecs[i].id_rs2);
                id_uses_rs1 = 1'(vecs[i].u1); id_uses_rs2 = 1'(vecs[i].u2);
                ex_rs1 = 5'(vecs[i].ex_rs1); ex_rs2 = 5'(vecs[i].ex_rs2);
                ex_rd = 5'(vecs[i].ex_rd); ex_memRead = 1'(vecs[i].mrd);
                ex_branch_taken = 1'(vecs[i].br);
                mem_rd = 5'(vecs[i].mem_rd); wb_rd = 5'(vecs[i].wb_rd);
                mem_regWrite = 1'(vecs[i].mem_rw); wb_regWrite = 1'(vecs[i].wb_rw);
                #1;
                chk($sformatf("vec%0d_en", i), en_bits(), vecs[i].exp_en);
                chk($sformatf("vec%0d_fl", i), fl_bits(), vecs[i].exp_fl);
                chk($sformatf("vec%0d_fwdA", i), int'(fwdA), vecs[i].exp_fa);
                chk($sformatf("vec%0d_fwdB", i), int'(fwdB), vecs[i].exp_fb);
                if ((vecs[i].exp_en & 5'b10000) == 0) exp_stall++;
                if (vecs[i].exp_fl == 2'b11) exp_flush++;
                @(negedge clk);
            end
            clear_inputs();
            #1;
            chk("table_stall", int'(stall_cycles), exp_stall);
            chk("table_flush", int'(flush_events), exp_flush);
        end

        // Memory wait: 3 frozen cycles (mem_req drops in the 2nd, a branch
        // arrives in the 3rd), released on dmem_ready.
        do_reset("wait");
        mem_req = 1'b1; dmem_ready = 1'b0;
        #1; chk("wait_c0_en", en_bits(), 0); chk("wait_c0_fl", fl_bits(), 0);
        @(negedge clk);
        mem_req = 1'b0;
        #1; chk("wait_c1_en", en_bits(), 0);
        @(negedge clk);
        ex_branch_taken = 1'b1;
        #1; chk("wait_c2_en", en_bits(), 0); chk("wait_c2_fl", fl_bits(), 0);
        @(negedge clk);
        ex_branch_taken = 1'b0; dmem_ready = 1'b1;
        #1; chk("wait_rel_en", en_bits(), 5'b11111);
        @(negedge clk);
        dmem_ready = 1'b0;
        #1;
        chk("wait_run_en", en_bits(), 5'b11111);
        chk("wait_stall", int'(stall_cycles), 3);
        chk("wait_flush", int'(flush_events), 0);
        chk("wait_tmo", int'(mem_timeout), 0);

        // Reset while in MEM_WAIT returns to RUN with cleared counters.
        mem_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        do_reset("midwait");
        #1;
        chk("midwait_en", en_bits(), 5'b11111);
        chk("midwait_stall", int'(stall_cycles), 0);

        // Timeout: RUN cycle + 4 MEM_WAIT cycles, then TIMEOUT.
        @(negedge clk);
        do_reset("tmo");
        mem_req = 1'b1; dmem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("tmo_c%0d_en", k), en_bits(), 0);
            chk($sformatf("tmo_c%0d_flag", k), int'(mem_timeout), 0);
            @(negedge clk);
        end
        mem_req = 1'b0; dmem_ready = 1'b1;
        #1;
        chk("tmo_flag", int'(mem_timeout), 1);
        chk("tmo_ready_en", en_bits(), 0);
        chk("tmo_stall5", int'(stall_cycles), 5);
        ex_branch_taken = 1'b1;
        for (int k = 0; k < 260; k++) @(negedge clk);
        #1;
        chk("tmo_hold_flag", int'(mem_timeout), 1);
        chk("tmo_hold_en", en_bits(), 0);
        chk("stall_sat", int'(stall_cycles), 255);
        chk("tmo_flush", int'(flush_events), 0);
        @(negedge clk);
        do_reset("clr");
        #1;
        chk("clr_flag", int'(mem_timeout), 0);
        chk("clr_stall", int'(stall_cycles), 0);
        chk("clr_en", en_bits(), 5'b11111);

        // Flush counter saturation on back-to-back branches.
        ex_branch_taken = 1'b1;
        for (int k = 0; k < 258; k++) @(negedge clk);
        #1;
        chk("flush_sat", int'(flush_events), 255);
        chk("flush_sat_stall", int'(stall_cycles), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RV32 pipeline. It drives enable and flush for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC. It handles load-use stalls, branch-redirect flushes, data-memory wait-state freezes with timeout, and EX-stage operand forwarding selects. It also keeps saturating stall and flush performance counters.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before entering TIMEOUT; 0 disables the timeout
CNT_W, 32, performance counter width
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock, all state updates on its rising edge
reset  in  1  synchronous, active-high reset
id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2
ex_rs1, ex_rs2  in  REG_ADDR_W  source registers held in ID/EX
ex_rd  in  REG_ADDR_W  destination register in ID/EX
ex_memRead  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolves a taken branch or jump (PC redirect)
mem_rd, wb_rd  in  REG_ADDR_W  destination registers in EX/MEM and MEM/WB
mem_regWrite, wb_regWrite  in  1  write-enable of those stages
mem_req  in  1  MEM stage issues a data-memory access (memRead|memWrite)
dmem_ready  in  1  data memory completes the access this cycle
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register load enables
if_id_flush, id_ex_flush  out  1  load a bubble (all-zero controls) instead of the input
fwdA, fwdB  out  2  ALU operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
mem_timeout  out  1  sticky error flag, set when the pipeline enters TIMEOUT
stall_cycles  out  CNT_W  cycles with pc_en=0
flush_events  out  CNT_W  cycles with a branch flush

Behaviour:
- Enables, flushes and forwarding selects are combinational (Mealy) from the current state and inputs. The FSM, wait counter, flag and perf counters are registered.
- Reset is asserted:
  - All enables 0, flushes 0, fwdA/fwdB 00.
  - On the next edge: state=RUN, wait_cnt=0, mem_timeout=0, both counters 0.
- freeze = (state==RUN && mem_req && !dmem_ready) || (state==MEM_WAIT && !dmem_ready) || state==TIMEOUT.
- Priority is freeze > branch > load-use.
  - freeze: every enable 0, every flush 0.
  - Branch (ex_branch_taken, no freeze): all enables 1, if_id_flush=1, id_ex_flush=1.
  - load_use = ex_memRead && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
  - Load-use (no branch, no freeze): pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en and mem_wb_en stay 1. Latency is exactly one bubble.
  - Otherwise all enables 1, flushes 0.
- FSM states are RUN, MEM_WAIT and TIMEOUT.
  - RUN to MEM_WAIT when mem_req && !dmem_ready; wait_cnt becomes 1.
  - In MEM_WAIT with dmem_ready=1: freeze releases in that same cycle, next state is RUN, wait_cnt becomes 0.
  - In MEM_WAIT with dmem_ready=0: wait_cnt increments. If MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT, next state is TIMEOUT.
  - TIMEOUT is terminal until reset: mem_timeout=1 and the pipeline stays frozen.
  - In MEM_WAIT, mem_req dropping does not release the freeze; only dmem_ready does.
- Forwarding:
  - fwdA=01 if mem_regWrite && mem_rd!=0 && mem_rd==ex_rs1.
  - Else fwdA=10 if wb_regWrite && wb_rd!=0 && wb_rd==ex_rs1.
  - Else fwdA=00. fwdB is identical on ex_rs2.
  - EX/MEM has priority. Forwarding selects are never gated by freeze.
- Counters:
  - stall_cycles increments on each non-reset cycle with pc_en=0 (freeze or load-use).
  - flush_events increments on each branch-flush cycle.
  - Both saturate at all-ones with no wrap.
- x0 never creates a hazard or a forward.

Decomposition:
- pipeline_pkg holds fwd_sel_t (FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10) and hz_state_t (RUN, MEM_WAIT, TIMEOUT).
- One combinational sub-module, forwarding_unit, computes fwdA/fwdB. The FSM, counters and enable logic stay in the top level.

Test Plan:
- Load-use: ex_memRead=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles goes 0 to 1. With ex_rd=0, no stall.
- Branch plus load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_en=1; flush_events=1; stall_cycles unchanged.
- Memory wait: mem_req=1, dmem_ready=0 for 3 cycles, then 1 -> all enables 0 for 3 cycles and 1 on the 4th; stall_cycles=3; state back to RUN.
- Timeout with MEM_TIMEOUT=4: dmem_ready held 0 -> TIMEOUT after 4 MEM_WAIT cycles, mem_timeout=1. It holds even when dmem_ready rises; reset clears it.
- Forwarding: mem_rd=wb_rd=ex_rs1=7, both regWrite=1 -> fwdA=01. With mem_regWrite=0 -> fwdA=10. With ex_rs2=0 -> fwdB=00.
- Reset mid-MEM_WAIT -> next cycle state=RUN, counters=0, enables follow the inputs.
